// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the UART RX deframer: frame configuration with
// between-frame apply, show-ahead receive FIFO with parity tags, error tracking and interrupts.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int LEVEL_W       = $clog2(FIFO_DEPTH) + 1,
  parameter int ERR_CNT_W     = 8,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [1:0]            cfg_data_width,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop,
  output logic                  cfg_pending,
  output logic [1:0]            data_width_option,
  output logic [1:0]            parity_option,
  output logic                  stop_bit_option,
  input  logic                  transaction_en,
  input  logic                  baudrate_clk_en,
  input  logic                  rx_fifo_wr,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr,
  output logic [LEVEL_W-1:0]    level,
  input  logic [LEVEL_W-1:0]    irq_threshold,
  output logic                  irq,
  output logic                  overrun_flag,
  output logic                  parity_flag,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  input  logic                  err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [LEVEL_W-1:0]   FULL_LVL = LEVEL_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]      TO_MAX   = TO_W'(TIMEOUT_TICKS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  logic [1:0] dw_q, dw_d, par_q, par_d, pend_dw_q, pend_dw_d, pend_par_q, pend_par_d;
  logic       stop_q, stop_d, pend_stop_q, pend_stop_d, pend_vld_q, pend_vld_d;
  logic       cfg_ok_s;

  logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   push_s, pop_s, full_s, empty_s, ovr_s, perr_s;
  logic                   ovr_q, ovr_d, parf_q, parf_d, irq_q, irq_d, timeout_s;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [DATA_WIDTH:0]    head_s;

  // Configuration: latch legal writes, apply whenever no frame is in progress
  always_comb begin
    dw_d        = dw_q;
    par_d       = par_q;
    stop_d      = stop_q;
    pend_dw_d   = pend_dw_q;
    pend_par_d  = pend_par_q;
    pend_stop_d = pend_stop_q;
    pend_vld_d  = pend_vld_q;
    cfg_ok_s    = cfg_wr && (cfg_parity != 2'd3);
    if (cfg_ok_s) begin
      pend_dw_d   = cfg_data_width;
      pend_par_d  = cfg_parity;
      pend_stop_d = cfg_stop;
      pend_vld_d  = 1'b1;
    end else begin
      pend_vld_d  = pend_vld_q;
    end
    if (!transaction_en && pend_vld_d) begin
      dw_d       = pend_dw_d;
      par_d      = pend_par_d;
      stop_d     = pend_stop_d;
      pend_vld_d = 1'b0;
    end else begin
      dw_d       = dw_q;
    end
  end

  // FIFO control, error tracking, timeout and interrupt next state
  always_comb begin
    empty_s  = (level_q == '0);
    full_s   = (level_q == FULL_LVL);
    pop_s    = rd_en && !empty_s;
    push_s   = rx_fifo_wr && (!full_s || pop_s);
    ovr_s    = rx_fifo_wr && !push_s;
    perr_s   = rx_fifo_wr && !rx_valid;
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
    // A coincident error event wins over err_clr, leaving the count at one
    ovr_d  = err_clr ? 1'b0 : ovr_q;
    parf_d = err_clr ? 1'b0 : parf_q;
    err_d  = err_clr ? '0 : err_q;
    if (ovr_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end
    if (perr_s) begin
      parf_d = 1'b1;
    end else begin
      parf_d = parf_d;
    end
    if ((ovr_s || perr_s) && (err_d != ERR_MAX)) begin
      err_d = err_d + ERR_CNT_W'(1);
    end else begin
      err_d = err_d;
    end
    timeout_s = (to_q == TO_MAX);
    if (push_s || pop_s || empty_s) begin
      to_d = '0;
    end else if (baudrate_clk_en && !timeout_s) begin
      to_d = to_q + TO_W'(1);
    end else begin
      to_d = to_q;
    end
    irq_d = ((irq_threshold != '0) && (level_q >= irq_threshold)) || timeout_s;
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_q        <= 2'b11;
      par_q       <= 2'b00;
      stop_q      <= 1'b0;
      pend_dw_q   <= 2'b00;
      pend_par_q  <= 2'b00;
      pend_stop_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovr_q       <= 1'b0;
      parf_q      <= 1'b0;
      err_q       <= '0;
      to_q        <= '0;
      irq_q       <= 1'b0;
    end else begin
      dw_q        <= dw_d;
      par_q       <= par_d;
      stop_q      <= stop_d;
      pend_dw_q   <= pend_dw_d;
      pend_par_q  <= pend_par_d;
      pend_stop_q <= pend_stop_d;
      pend_vld_q  <= pend_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovr_q       <= ovr_d;
      parf_q      <= parf_d;
      err_q       <= err_d;
      to_q        <= to_d;
      irq_q       <= irq_d;
    end
  end

  // Storage array; contents are don't-care until pointed at by a valid entry
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {~rx_valid, rx_data};
    end
  end

  assign head_s            = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rd_valid          = (level_q != '0);
  assign rd_data           = head_s[DATA_WIDTH-1:0];
  assign rd_perr           = head_s[DATA_WIDTH];
  assign level             = level_q;
  assign cfg_pending       = pend_vld_q;
  assign data_width_option = dw_q;
  assign parity_option     = par_q;
  assign stop_bit_option   = stop_q;
  assign overrun_flag      = ovr_q;
  assign parity_flag       = parf_q;
  assign err_cnt           = err_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized and directed bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_data_width = 2'd0, cfg_parity = 2'd0;
  logic       cfg_stop = 1'b0, cfg_pending;
  logic [1:0] data_width_option, parity_option;
  logic       stop_bit_option;
  logic       transaction_en = 1'b0, baudrate_clk_en = 1'b0, rx_fifo_wr = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b1, rd_en = 1'b0, rd_valid, rd_perr;
  logic [7:0] rd_data;
  logic [4:0] level, irq_threshold = 5'd0;
  logic       irq, overrun_flag, parity_flag, err_clr = 1'b0;
  logic [7:0] err_cnt;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  logic [8:0] mq[$];
  bit   m_ovr, m_par, m_irq, m_pend, m_stop, p_stop;
  int   m_err, m_to;
  logic [1:0] m_dw, m_popt, p_dw, p_par;

  uart_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_data_width(cfg_data_width),
    .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .cfg_pending(cfg_pending),
    .data_width_option(data_width_option), .parity_option(parity_option),
    .stop_bit_option(stop_bit_option), .transaction_en(transaction_en),
    .baudrate_clk_en(baudrate_clk_en), .rx_fifo_wr(rx_fifo_wr), .rx_data(rx_data),
    .rx_valid(rx_valid), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_perr(rd_perr), .level(level), .irq_threshold(irq_threshold), .irq(irq),
    .overrun_flag(overrun_flag), .parity_flag(parity_flag), .err_cnt(err_cnt),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [8:0] hd;
    hd = (mq.size() != 0) ? mq[0] : 9'd0;
    check_eq("level", level, mq.size());
    check_eq("rd_valid", rd_valid, mq.size() != 0);
    check_eq("rd_data", rd_data, hd[7:0]);
    check_eq("rd_perr", rd_perr, hd[8]);
    check_eq("overrun_flag", overrun_flag, m_ovr);
    check_eq("parity_flag", parity_flag, m_par);
    check_eq("err_cnt", err_cnt, m_err);
    check_eq("irq", irq, m_irq);
    check_eq("data_width_option", data_width_option, m_dw);
    check_eq("parity_option", parity_option, m_popt);
    check_eq("stop_bit_option", stop_bit_option, m_stop);
    check_eq("cfg_pending", cfg_pending, m_pend);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 0; m_par = 0; m_irq = 0; m_pend = 0; m_err = 0; m_to = 0;
    m_dw = 2'b11; m_popt = 2'b00; m_stop = 0;
  endtask

  // advance one clock: update the model from the held inputs, then compare
  task automatic step();
    bit pop, push, ovr, pe, nirq;
    pop  = rd_en && (mq.size() != 0);
    push = rx_fifo_wr && ((mq.size() < 16) || pop);
    ovr  = rx_fifo_wr && !push;
    pe   = rx_fifo_wr && !rx_valid;
    nirq = ((irq_threshold != 0) && (mq.size() >= irq_threshold)) || (m_to == 40);
    if (push || pop || mq.size() == 0) m_to = 0;
    else if (baudrate_clk_en && m_to < 40) m_to++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({~rx_valid, rx_data});
    if (err_clr) begin m_ovr = 0; m_par = 0; m_err = 0; end
    if (ovr) m_ovr = 1;
    if (pe) m_par = 1;
    if ((ovr || pe) && m_err < 255) m_err++;
    if (cfg_wr && cfg_parity != 2'd3) begin
      p_dw = cfg_data_width; p_par = cfg_parity; p_stop = cfg_stop; m_pend = 1;
    end
    if (m_pend && !transaction_en) begin
      m_dw = p_dw; m_popt = p_par; m_stop = p_stop; m_pend = 0;
    end
    m_irq = nirq;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic push_char(input logic [7:0] d, input logic v);
    rx_fifo_wr = 1'b1; rx_data = d; rx_valid = v;
    step();
    rx_fifo_wr = 1'b0; rx_valid = 1'b1;
  endtask

  task automatic pop_char();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) if (mq.size() != 0) pop_char();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    p_dw = 2'd0; p_par = 2'd0; p_stop = 0;
    do_reset();
    check_eq("reset_dw", data_width_option, 32'd3);
    @(posedge clk); #1;

    // configuration deferral
    transaction_en = 1'b1;
    cfg_wr = 1'b1; cfg_data_width = 2'b00; cfg_parity = 2'd1; cfg_stop = 1'b0;
    step();
    cfg_wr = 1'b0;
    check_eq("defer_pending", cfg_pending, 32'd1);
    check_eq("defer_dw_held", data_width_option, 32'd3);
    step();
    transaction_en = 1'b0;
    step();
    check_eq("applied_dw", data_width_option, 32'd0);
    check_eq("applied_par", parity_option, 32'd1);
    check_eq("applied_pending", cfg_pending, 32'd0);

    // illegal parity is ignored
    cfg_wr = 1'b1; cfg_data_width = 2'b10; cfg_parity = 2'd3; cfg_stop = 1'b1;
    step();
    cfg_wr = 1'b0;
    check_eq("illegal_dw", data_width_option, 32'd0);
    check_eq("illegal_stop", stop_bit_option, 32'd0);

    // fill, full and overrun
    for (int i = 0; i < 16; i++) push_char(8'(i), 1'b1);
    push_char(8'hAA, 1'b1);
    check_eq("full_level", level, 32'd16);
    check_eq("full_ovr", overrun_flag, 32'd1);
    check_eq("full_err", err_cnt, 32'd1);
    check_eq("full_head", rd_data, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check_eq("read_order", rd_data, i);
      pop_char();
    end

    // simultaneous push and pop on full FIFO
    err_clr = 1'b1; step(); err_clr = 1'b0;
    for (int i = 0; i < 16; i++) push_char(8'(8'h10 + i), 1'b1);
    rd_en = 1'b1;
    push_char(8'h55, 1'b1);
    rd_en = 1'b0;
    check_eq("pp_level", level, 32'd16);
    check_eq("pp_ovr", overrun_flag, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("pp_last", rd_data, 32'h55);
      pop_char();
    end

    // parity tagging and error clear
    push_char(8'h3C, 1'b0);
    check_eq("perr_tag", rd_perr, 32'd1);
    check_eq("perr_flag", parity_flag, 32'd1);
    check_eq("perr_cnt", err_cnt, 32'd1);
    err_clr = 1'b1;
    push_char(8'h77, 1'b0);
    err_clr = 1'b0;
    check_eq("clr_override_cnt", err_cnt, 32'd1);
    check_eq("clr_override_flag", parity_flag, 32'd1);
    drain();

    // fill interrupt
    irq_threshold = 5'd4;
    for (int i = 0; i < 4; i++) push_char(8'(8'hC0 + i), 1'b1);
    check_eq("fill_irq_lag", irq, 32'd0);
    step();
    check_eq("fill_irq_set", irq, 32'd1);
    pop_char();
    step();
    check_eq("fill_irq_clr", irq, 32'd0);
    drain();

    // timeout interrupt
    irq_threshold = 5'd0;
    push_char(8'h5A, 1'b1);
    baudrate_clk_en = 1'b1;
    repeat (40) step();
    baudrate_clk_en = 1'b0;
    step();
    check_eq("timeout_irq", irq, 32'd1);
    pop_char();
    check_eq("timeout_level", level, 32'd0);
    step();
    check_eq("timeout_irq_clr", irq, 32'd0);

    // error counter saturation
    for (int i = 0; i < 300; i++) push_char(8'($urandom), 1'($urandom_range(0, 1)));
    check_eq("err_sat", err_cnt, 32'd255);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    drain();

    // randomized traffic in segments of varying intensity
    for (int seg = 0; seg < 30; seg++) begin
      int p_wr, p_rd, p_bd;
      p_wr = $urandom_range(0, 90);
      p_rd = $urandom_range(0, 90);
      p_bd = $urandom_range(10, 100);
      irq_threshold = 5'($urandom_range(0, 17));
      for (int c = 0; c < 100; c++) begin
        rx_fifo_wr      = ($urandom_range(0, 99) < p_wr);
        rx_data         = 8'($urandom);
        rx_valid        = ($urandom_range(0, 9) != 0);
        rd_en           = ($urandom_range(0, 99) < p_rd);
        baudrate_clk_en = ($urandom_range(0, 99) < p_bd);
        err_clr         = ($urandom_range(0, 49) == 0);
        cfg_wr          = ($urandom_range(0, 19) == 0);
        cfg_data_width  = 2'($urandom);
        cfg_parity      = 2'($urandom);
        cfg_stop        = 1'($urandom);
        if ($urandom_range(0, 9) == 0) transaction_en = ~transaction_en;
        step();
      end
    end
    rx_fifo_wr = 1'b0; rd_en = 1'b0; err_clr = 1'b0; cfg_wr = 1'b0; baudrate_clk_en = 1'b0;

    // reset mid-frame with a pending configuration and a non-empty FIFO
    transaction_en = 1'b1;
    push_char(8'h11, 1'b0);
    cfg_wr = 1'b1; cfg_data_width = 2'b01; cfg_parity = 2'd2; cfg_stop = 1'b1;
    step();
    cfg_wr = 1'b0;
    do_reset();
    transaction_en = 1'b0;
    step();
    check_eq("post_reset_dw", data_width_option, 32'd3);
    check_eq("post_reset_level", level, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
